updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the count width in bits.
REQ-002 The block SHALL have parameter PRESC_W, default 4, giving the prescaler setting width in bits.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port enable, input, 1: high permits the prescaler, and therefore counting, to advance.
REQ-006 Port down, input, 1: count direction; 1 = decrement, 0 = increment.
REQ-007 Port load, input, 1: synchronous load of data_in.
REQ-008 Port data_in, input, WIDTH: the load value.
REQ-009 Port limit, input, WIDTH: the upper bound; the legal count range is 0..limit.
REQ-010 Port mode, input, 2: 00 WRAP, 01 SATURATE, 10 ONESHOT; 11 SHALL behave as WRAP.
REQ-011 Port presc, input, PRESC_W: one step SHALL occur per presc+1 enabled cycles.
REQ-012 Port count, output, WIDTH: the registered count value.
REQ-013 Port tc, output, 1: registered one-cycle terminal-count pulse.
REQ-014 Port done, output, 1: sticky flag set when a ONESHOT run has completed.
REQ-015 Port ovf, output, 1: sticky flag set on any wrap event.

Function
REQ-016 Priority SHALL be rst > load > tick > hold.
REQ-017 Prescaler counter: it SHALL increment only on enable=1; a tick SHALL be generated, and the counter cleared, when it equals presc; presc=0 SHALL give a tick on every enabled cycle.
REQ-018 enable=0 SHALL freeze both the prescaler and the count; prescaler phase SHALL be kept.
REQ-019 On load, count SHALL take min(data_in, limit), and done, ovf, tc and the prescaler SHALL be cleared.
REQ-020 An up tick with count<limit SHALL give count+1; a down tick with 0<count<=limit SHALL give count-1.
REQ-021 An up tick with count>=limit SHALL be a boundary step; the result SHALL be count=0 in WRAP, and count=limit in SATURATE and ONESHOT.
REQ-022 A down tick with count=0 SHALL be a boundary step; the result SHALL be count=limit in WRAP, and count=0 in SATURATE and ONESHOT.
REQ-023 A down tick with count>limit (limit lowered at run time) SHALL set count=limit, and SHALL NOT be a boundary step.
REQ-024 A boundary step SHALL assert tc for exactly the one cycle that follows the step edge.
REQ-025 A boundary step in WRAP mode SHALL set ovf; ovf SHALL be cleared only by load or rst.
REQ-026 A boundary step in ONESHOT mode SHALL set done.
REQ-027 While done=1, ticks SHALL be ignored: count held, no tc.
REQ-028 With limit=0, count SHALL stay 0 and every tick SHALL be a boundary step.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH internally, with no out-of-range count ever produced by a step or a load.
REQ-030 A mode change SHALL take effect on the next tick and SHALL NOT alter count by itself.

Reset
REQ-031 rst=1 at a clock edge SHALL set count=0, tc=0, done=0, ovf=0 and prescaler=0, overriding any simultaneous load or tick.
REQ-032 Reset asserted mid-count SHALL take effect on the next edge; counting SHALL resume from 0 on the first enabled cycle after release.

Structure
REQ-033 The mode encodings (WRAP, SATURATE, ONESHOT) SHALL be defined as constants in shared package counter_pkg.
REQ-034 The prescaler SHALL be a sub-module tick_prescaler (parameter PRESC_W; ports clk, rst, clr, enable, presc, tick).
REQ-035 All outputs SHALL be driven directly from flops, with no combinational paths from inputs to outputs.

Verification (WIDTH=4, PRESC_W=4)
REQ-036 WRAP mode, up, limit=9, presc=0, enable=1 from reset -> count 0,1,...,9,0; tc high for one cycle alongside the 0; ovf=1 thereafter.
REQ-037 SATURATE mode, down, limit=5, load data_in=2 -> count 2,1,0,0,0; tc pulses on each tick taken at 0; ovf stays 0.
REQ-038 presc=2, up, enable toggled low for 5 cycles mid-run -> count steps every 3rd enabled cycle; no extra or lost step across the pause.
REQ-039 ONESHOT mode, up, limit=3 -> count 0,1,2,3; next tick sets done=1 with one tc pulse; further ticks hold 3 with no tc; load data_in=0 clears done.
REQ-040 Load and clamp:
- load data_in=12 with limit=9 -> count=9.
- load with a tick in the same cycle -> load wins.
- rst with load asserted during counting -> count=0, flags=0 on the next edge.
REQ-041 Limit lowered at run time:
- WRAP mode, up, count=7, limit changed 9->4 -> next tick gives count=0, ovf=1, tc pulse.
- Down direction, same condition -> count=4, no tc.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter: mode encodings and
// a helper that folds the reserved encoding onto WRAP.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

    // The reserved encoding behaves exactly like WRAP.
    function automatic logic mode_wraps(input logic [1:0] m);
        return (m == MODE_WRAP) || (m == MODE_RESERVED);
    endfunction

    function automatic logic mode_oneshot(input logic [1:0] m);
        return m == MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by presc+1; tick marks the enabled cycle on which
// the phase counter matches presc. Phase is held while enable is low.
module tick_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] phase;

    assign tick = enable && (phase == presc);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (enable) begin
            if (phase == presc) begin
                phase <= '0;
            end else begin
                phase <= phase + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Prescaled up/down counter over 0..limit with WRAP, SATURATE and ONESHOT
// boundary behaviour, a registered terminal-count pulse and sticky flags.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               down,
    input  logic               load,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [WIDTH-1:0]   limit,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               done,
    output logic               ovf
);

    logic             tick;
    logic             wraps;
    logic             boundary;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_value;

    tick_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clr    (load),
        .enable (enable),
        .presc  (presc),
        .tick   (tick)
    );

    assign wraps      = mode_wraps(mode);
    assign load_value = (data_in > limit) ? limit : data_in;

    // A count left above a lowered limit is pulled back to limit when
    // stepping down; that correction is not a boundary step.
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        if (!down) begin
            if (count < limit) begin
                next_count = count + WIDTH'(1);
            end else begin
                boundary   = 1'b1;
                next_count = wraps ? '0 : limit;
            end
        end else if (count > limit) begin
            next_count = limit;
        end else if (count == '0) begin
            boundary   = 1'b1;
            next_count = wraps ? limit : '0;
        end else begin
            next_count = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_value;
            tc    <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (tick && !done) begin
                count <= next_count;
                if (boundary) begin
                    tc <= 1'b1;
                    if (wraps) begin
                        ovf <= 1'b1;
                    end
                    if (mode_oneshot(mode)) begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: directed scenarios then random stimulus,
// each edge predicted by an arithmetic reference model into a queue.
module tb_updown_mod_counter;
    localparam int WIDTH   = 4;
    localparam int PRESC_W = 4;
    localparam int EW      = WIDTH + 3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst     = 1'b1;
    logic               enable  = 1'b0;
    logic               down    = 1'b0;
    logic               load    = 1'b0;
    logic [WIDTH-1:0]   data_in = '0;
    logic [WIDTH-1:0]   limit   = '0;
    logic [1:0]         mode    = 2'b00;
    logic [PRESC_W-1:0] presc   = '0;
    logic [WIDTH-1:0]   count;
    logic               tc;
    logic               done;
    logic               ovf;

    updown_mod_counter #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .down    (down),
        .load    (load),
        .data_in (data_in),
        .limit   (limit),
        .mode    (mode),
        .presc   (presc),
        .count   (count),
        .tc      (tc),
        .done    (done),
        .ovf     (ovf)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;
    int cyc_n  = 0;

    // reference model state
    int m_count = 0;
    int m_ph    = 0;
    bit m_tc    = 0;
    bit m_done  = 0;
    bit m_ovf   = 0;

    task automatic hit_boundary(input int result);
        m_count = result;
        m_tc    = 1;
        if (mode != 2'd1 && mode != 2'd2) m_ovf = 1;
        if (mode == 2'd2) m_done = 1;
    endtask

    task automatic model_edge();
        int lim;
        int din;
        bit tick;
        lim = int'(limit);
        din = int'(data_in);
        if (rst) begin
            m_count = 0; m_tc = 0; m_done = 0; m_ovf = 0; m_ph = 0;
        end else if (load) begin
            m_count = (din > lim) ? lim : din;
            m_tc = 0; m_done = 0; m_ovf = 0; m_ph = 0;
        end else begin
            m_tc = 0;
            tick = 0;
            if (enable) begin
                if (m_ph == int'(presc)) begin
                    tick = 1;
                    m_ph = 0;
                end else begin
                    m_ph = (m_ph + 1) % (1 << PRESC_W);
                end
            end
            if (tick && !m_done) begin
                if (!down) begin
                    if (m_count < lim) m_count = m_count + 1;
                    else hit_boundary((mode == 2'd1 || mode == 2'd2) ? lim : 0);
                end else begin
                    if (m_count > lim) m_count = lim;
                    else if (m_count == 0) hit_boundary((mode == 2'd1 || mode == 2'd2) ? 0 : lim);
                    else m_count = m_count - 1;
                end
            end
        end
        exp_q.push_back({WIDTH'(m_count), m_tc, m_done, m_ovf});
    endtask

    // driver: inputs are set between edges, the model predicts each edge
    task automatic clk_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1; data_in = v;
        clk_step();
        load = 1'b0;
    endtask

    // monitor: outputs are valid every cycle, compared mid-cycle
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        cyc_n++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {count, tc, done, ovf};
            n_vec++;
            if (a !== e) begin
                n_miss++;
                $display("FAIL cycle_%0d: count/tc/done/ovf got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                         cyc_n, a[EW-1:3], a[2], a[1], a[0], e[EW-1:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        // reset
        rst = 1'b1;
        run(2);
        rst = 1'b0;

        // WRAP up, limit 9, every cycle: 0..9,0 with tc and ovf
        mode = 2'b00; down = 1'b0; limit = 4'd9; presc = '0; enable = 1'b1;
        run(12);

        // SATURATE down from 2 with limit 5
        mode = 2'b01; down = 1'b1; limit = 4'd5;
        do_load(4'd2);
        run(5);

        // prescaler 2 with a 5-cycle pause mid-run
        mode = 2'b00; down = 1'b0; limit = 4'd15; presc = 4'd2;
        do_load(4'd0);
        run(7);
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(8);

        // ONESHOT up to 3, then done holds, load clears it
        mode = 2'b10; limit = 4'd3; presc = '0;
        do_load(4'd0);
        run(7);
        do_load(4'd0);
        run(2);

        // load clamp, load beats tick, reset beats load
        mode = 2'b00; limit = 4'd9;
        do_load(4'd12);
        run(2);
        do_load(4'd5);
        run(3);
        rst = 1'b1; load = 1'b1; data_in = 4'd7;
        clk_step();
        rst = 1'b0; load = 1'b0;
        run(3);

        // limit lowered below the count, up then down
        mode = 2'b00; down = 1'b0; limit = 4'd9;
        do_load(4'd7);
        limit = 4'd4;
        run(3);
        limit = 4'd9;
        do_load(4'd7);
        limit = 4'd4; down = 1'b1;
        run(3);

        // limit 0: every tick is a boundary step
        limit = 4'd0; down = 1'b0;
        do_load(4'd0);
        run(3);
        down = 1'b1;
        run(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            load    = ($urandom_range(0, 15) == 0);
            enable  = ($urandom_range(0, 3) != 0);
            down    = $urandom_range(0, 1);
            data_in = WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) limit = WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) presc = PRESC_W'($urandom_range(0, 3));
            clk_step();
        end
        rst = 1'b0; load = 1'b0;

        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
